// File: rtl/alu_muldiv_seq.sv
// Multicycle MIPS MULT/MULTU/DIV/DIVU sequencer that time-shares one external 32-bit ALU.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up afterwards.
package alu_muldiv_seq_pkg;
    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;
endpackage

module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output aluop_t      alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_o,
    input  logic        alu_z
);

    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [2:0] {
        IDLE,
        NEGA,
        NEGB,
        ITER,
        FIX1,
        FIX2,
        FIX3,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        x_q, x_d;      // rt on entry, then M (multiplicand) or D (divisor)
    logic [31:0]        l_q, l_d;      // L (multiplier / low product) or Q (quotient)
    logic [31:0]        p_q, p_d;      // rs on entry, then P (high product) or R (remainder)
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               lz_q, lz_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_div;
    logic               is_signed;
    logic               neg_res;
    logic               mul_neg;
    logic [31:0]        div_a;
    logic               carry;
    logic               borrow;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign neg_res   = sa_q ^ sb_q;
    assign mul_neg   = ~is_div & neg_res;
    assign div_a     = {p_q[30:0], l_q[31]};

    assign hi = hi_q;
    assign lo = lo_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            x_q     <= 32'h0;
            l_q     <= 32'h0;
            p_q     <= 32'h0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            lz_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            l_q     <= l_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            lz_q    <= lz_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        l_d     = l_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        lz_d    = lz_q;
        cnt_d   = cnt_q;
        alu_op  = ALU_ADD;
        alu_a   = 32'h0;
        alu_b   = 32'h0;
        busy    = 1'b0;
        done    = 1'b0;
        carry   = 1'b0;
        borrow  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    op_d    = op;
                    p_d     = rs;
                    x_d     = rt;
                    state_d = NEGA;
                end else begin
                    state_d = IDLE;
                end
            end

            NEGA: begin
                busy = 1'b1;
                if (is_signed && p_q[31]) begin
                    alu_op = ALU_SUB;
                    alu_b  = p_q;
                end else begin
                    alu_a  = p_q;
                end
                sa_d    = is_signed & p_q[31];
                l_d     = alu_o;
                state_d = NEGB;
            end

            NEGB: begin
                busy = 1'b1;
                if (is_signed && x_q[31]) begin
                    alu_op = ALU_SUB;
                    alu_b  = x_q;
                end else begin
                    alu_a  = x_q;
                end
                sb_d = is_signed & x_q[31];
                // Multiply wants |rs| as M and |rt| shifting in L; divide keeps |rs| in Q.
                if (is_div) begin
                    x_d = alu_o;
                end else begin
                    x_d = l_q;
                    l_d = alu_o;
                end
                p_d     = 32'h0;
                cnt_d   = '0;
                state_d = ITER;
            end

            ITER: begin
                busy = 1'b1;
                if (!is_div) begin
                    alu_a = p_q;
                    alu_b = l_q[0] ? x_q : 32'h0;
                    carry = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_o[31]);
                    p_d   = {carry, alu_o[31:1]};
                    l_d   = {alu_o[0], l_q[31:1]};
                end else begin
                    alu_op = ALU_SUB;
                    alu_a  = div_a;
                    alu_b  = x_q;
                    borrow = (~alu_a[31] & alu_b[31]) | (~(alu_a[31] ^ alu_b[31]) & alu_o[31]);
                    // The bit shifted out of R makes the partial remainder exceed any divisor.
                    if (p_q[31] || !borrow) begin
                        p_d = alu_o;
                        l_d = {l_q[30:0], 1'b1};
                    end else begin
                        p_d = div_a;
                        l_d = {l_q[30:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = FIX1;
                end
            end

            FIX1: begin
                busy = 1'b1;
                if (neg_res) begin
                    alu_op = ALU_SUB;
                    alu_b  = l_q;
                end else begin
                    alu_a  = l_q;
                end
                lo_d    = alu_o;
                lz_d    = alu_z;
                state_d = FIX2;
            end

            FIX2: begin
                busy = 1'b1;
                if (mul_neg) begin
                    alu_op = ALU_NOR;
                    alu_a  = p_q;
                    alu_b  = p_q;
                end else if (is_div && sa_q) begin
                    alu_op = ALU_SUB;
                    alu_b  = p_q;
                end else begin
                    alu_a  = p_q;
                end
                hi_d    = alu_o;
                state_d = FIX3;
            end

            FIX3: begin
                busy = 1'b1;
                // Carry of the low-word negate propagates into ~P only when L was zero.
                alu_a   = hi_q;
                alu_b   = mul_neg ? {31'h0, lz_q} : 32'h0;
                hi_d    = alu_o;
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multicycle sequencer that executes MIPS MULT, MULTU, DIV and DIVU by time-sharing one 32-bit ALU instance.
- Takes rs/rt on a start pulse and drives ALUOP/A/B each cycle.
- Runs sign correction, 32 shift-add or restoring-subtract iterations, and result correction.
- Writes HI/LO. Sits beside the execute stage; the pipeline stalls on busy.

Parameters:
- ITERS, 32, number of iterate cycles (equals WORD_W); changing it is unsupported.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- start  in  1  request; sampled in IDLE or DONE only
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- rs  in  32  dividend / multiplicand, sampled with start
- rt  in  32  divisor / multiplier, sampled with start
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; hi/lo valid from this cycle on
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- alu_op  out  aluop_t  ALUOP driven to the shared ALU
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_o  in  32  ALU result
- alu_z  in  1  ALU zero flag

Behaviour:
Reset, asynchronous on nRST low:
- State goes to IDLE; hi=lo=0; busy=0; done=0; alu_op=ALU_ADD; alu_a=alu_b=0.
- Reset mid-operation abandons the operation; no done is generated.

States, one cycle each unless noted:
- IDLE / DONE: on start=1, latch op, rs, rt into working registers and go to NEGA. DONE otherwise returns to IDLE. done=1 only in DONE.
- NEGA: if op is signed and rs[31]=1, ALU_SUB 0-rs gives |rs|; otherwise ALU_ADD rs+0. Record sa=rs[31]&signed.
- NEGB: same treatment for rt. Record sb. Clear counter, then go to ITER.
- ITER, 32 cycles, counter 0..31:
  - Multiply, registers {P,L}: ALU_ADD P + (L[0] ? M : 0).
    - carry=(A31&B31)|((A31|B31)&~O31).
    - Then {P,L} <= {carry,O,L[31:1]}.
  - Divide, registers {R,Q}, D=|rt|: A={R[30:0],Q[31]}, ALU_SUB A-D, r33=R[31].
    - borrow=(~A31&B31)|(~(A31^B31)&O31).
    - If r33|~borrow: R<=O and Q<={Q[30:0],1}. Else R<=A and Q<={Q[30:0],0}.
- FIX1/FIX2/FIX3:
  - MULT with sa^sb=1, 64-bit negate:
    - FIX1: lo<=0-L; capture lz=alu_z.
    - FIX2: NOR(P,P) gives ~P.
    - FIX3: ADD ~P + lz gives hi.
  - DIV: FIX1 negates Q if sa^sb. FIX2 negates R if sa. FIX3 is ADD 0 (no-op).
  - Unsigned ops, or no negation needed: pass-through ADD x+0.
  - Go to DONE; hi/lo update in FIX states and are held until the next accepted start.

Timing:
- Fixed latency. start sampled at edge t0; busy=1 in NEGA..FIX3, i.e. 37 cycles; done=1 in the cycle after FIX3.
- start while busy is ignored. start in DONE is accepted, giving back-to-back operations with one DONE cycle between them.
- alu_op/alu_a/alu_b are combinational from state and working registers. ALU flag V is ignored.

Boundaries:
- DIVU by 0: lo=0xFFFFFFFF, hi=rs.
- DIV by 0: lo=0xFFFFFFFF if rs>=0, else 0x00000001; hi=rs.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0.
- op changing while busy has no effect; the latched op is used.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 38 cycles after the start edge.
- MULT -3*7 (0xFFFFFFFD, 7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV -5/0 -> lo=1, hi=0xFFFFFFFB.
- start pulses during busy are ignored. start held in DONE launches a second MULTU 3*4 -> hi=0, lo=12.
- nRST low at ITER count 10 -> immediately hi=lo=0, busy=0, no done. A new op after release completes correctly.
